// File: rtl/hazard_pkg.sv
`default_nettype none
// ============================================================================
// Module   : hazard_pkg
// Purpose  : Shared types and helpers for the pipeline hazard controller.
//            Defines the operand-forward select encoding, the per-stage
//            destination tag record and the tag-match helper.
// Revision : 1.0 - initial release
// ============================================================================
package hazard_pkg;

  typedef enum logic [1:0] {
    FWD_GPR = 2'b00,
    FWD_MEM = 2'b01,
    FWD_EX  = 2'b10
  } fwd_sel_t;

  typedef struct packed {
    logic       valid;
    logic       wr_en;
    logic [4:0] wr_reg;
    logic       is_load;
  } stage_tag_t;

  localparam logic [4:0] REG_ZERO = 5'd0;

  // An empty pipeline slot: nothing valid, nothing written.
  localparam stage_tag_t TAG_INVALID = '0;

  // A stage produces register r only if it really writes a GPR and r is not
  // the hardwired zero register.
  function automatic logic tag_match(input stage_tag_t t, input logic [4:0] r);
    return t.valid && t.wr_en && (t.wr_reg == r) && (r != REG_ZERO);
  endfunction

endpackage
`default_nettype wire

// File: rtl/fwd_select.sv
`default_nettype none
// ============================================================================
// Module   : fwd_select
// Purpose  : Per-operand forward select and load-use detection.
// Ports    : i_src      - decode source register
//            i_uses     - decode instruction actually reads i_src
//            i_ex_tag   - destination tag of the execute stage
//            i_mem_tag  - destination tag of the memory stage
//            o_fwd_sel  - operand mux select (EX > MEM > GPR)
//            o_load_match - operand depends on a load still in flight
// Revision : 1.0 - initial release
// ============================================================================
module fwd_select
  import hazard_pkg::*;
(
  input  logic [4:0] i_src,
  input  logic       i_uses,
  input  stage_tag_t i_ex_tag,
  input  stage_tag_t i_mem_tag,
  output fwd_sel_t   o_fwd_sel,
  output logic       o_load_match
);

  logic w_ex_hit;
  logic w_mem_hit;

  assign w_ex_hit     = i_uses && tag_match(i_ex_tag, i_src);
  assign w_mem_hit    = i_uses && tag_match(i_mem_tag, i_src);
  assign o_load_match = (w_ex_hit && i_ex_tag.is_load) ||
                        (w_mem_hit && i_mem_tag.is_load);

  // A load result is not yet available on either bypass path; the operand
  // will be stalled anyway, so the select is pinned to GPR for determinism.
  always_comb begin
    o_fwd_sel = FWD_GPR;
    if (o_load_match) begin
      o_fwd_sel = FWD_GPR;
    end else if (w_ex_hit) begin
      o_fwd_sel = FWD_EX;
    end else if (w_mem_hit) begin
      o_fwd_sel = FWD_MEM;
    end
  end

endmodule
`default_nettype wire

// File: rtl/hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : hazard_controller
// Purpose  : Hazard / forwarding controller for the 5-stage core. Shadows the
//            destination tags of the execute and memory stages and derives
//            operand forward selects, stall/bubble/freeze controls and a
//            saturating hazard-stall counter.
// Ports    : clk, reset        - core clock, synchronous active-high reset
//            dec_*, rs, rt     - decoded instruction info from the decoder
//            mem_busy          - data memory not ready (freezes pipeline)
//            forward_a/_b      - decode operand selects (10 EX, 01 MEM, 00 GPR)
//            stall_fetch/_decode, bubble_execute, freeze - pipeline controls
//            stall_cycles      - load-use stall cycles since reset
// Revision : 1.0 - initial release
// ============================================================================
module hazard_controller
  import hazard_pkg::*;
#(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             dec_valid,
  input  logic [4:0]       rs,
  input  logic [4:0]       rt,
  input  logic             dec_uses_rs,
  input  logic             dec_uses_rt,
  input  logic             dec_wr_en,
  input  logic [4:0]       dec_wr_reg,
  input  logic             dec_is_load,
  input  logic             mem_busy,
  output logic [1:0]       forward_a,
  output logic [1:0]       forward_b,
  output logic             stall_fetch,
  output logic             stall_decode,
  output logic             bubble_execute,
  output logic             freeze,
  output logic [CNT_W-1:0] stall_cycles
);

  localparam logic [CNT_W-1:0] C_CNT_MAX = {CNT_W{1'b1}};

  stage_tag_t       r_ex_tag;
  stage_tag_t       r_mem_tag;
  logic [CNT_W-1:0] r_stall_cycles;

  fwd_sel_t   w_fwd_a;
  fwd_sel_t   w_fwd_b;
  logic       w_load_a;
  logic       w_load_b;
  logic       w_load_hazard;
  stage_tag_t w_dec_tag;

  fwd_select u_fwd_a (
    .i_src        (rs),
    .i_uses       (dec_uses_rs),
    .i_ex_tag     (r_ex_tag),
    .i_mem_tag    (r_mem_tag),
    .o_fwd_sel    (w_fwd_a),
    .o_load_match (w_load_a)
  );

  fwd_select u_fwd_b (
    .i_src        (rt),
    .i_uses       (dec_uses_rt),
    .i_ex_tag     (r_ex_tag),
    .i_mem_tag    (r_mem_tag),
    .o_fwd_sel    (w_fwd_b),
    .o_load_match (w_load_b)
  );

  assign w_load_hazard = dec_valid && (w_load_a || w_load_b);

  always_comb begin
    w_dec_tag         = TAG_INVALID;
    w_dec_tag.valid   = 1'b1;
    w_dec_tag.wr_en   = dec_wr_en;
    w_dec_tag.wr_reg  = dec_wr_reg;
    w_dec_tag.is_load = dec_is_load;
  end

  // A frozen pipeline holds everything, including the counter; the hazard
  // is simply re-evaluated once mem_busy drops.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_ex_tag       <= TAG_INVALID;
      r_mem_tag      <= TAG_INVALID;
      r_stall_cycles <= '0;
    end else if (!mem_busy) begin
      r_mem_tag <= r_ex_tag;
      if (w_load_hazard || !dec_valid) begin
        r_ex_tag <= TAG_INVALID;
      end else begin
        r_ex_tag <= w_dec_tag;
      end
      if (w_load_hazard && (r_stall_cycles != C_CNT_MAX)) begin
        r_stall_cycles <= r_stall_cycles + 1'b1;
      end
    end
  end

  assign forward_a      = w_fwd_a;
  assign forward_b      = w_fwd_b;
  assign stall_fetch    = w_load_hazard | mem_busy;
  assign stall_decode   = w_load_hazard | mem_busy;
  assign freeze         = mem_busy;
  assign bubble_execute = w_load_hazard & ~mem_busy;
  assign stall_cycles   = r_stall_cycles;

endmodule
`default_nettype wire

// File: tb/tb_hazard_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_hazard_controller
// Purpose  : Directed self-checking bench for hazard_controller. A second
//            instance with a 4-bit counter shares the stimulus to exercise
//            counter saturation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_hazard_controller;

  logic        clk;
  logic        reset;
  logic        dec_valid;
  logic [4:0]  rs;
  logic [4:0]  rt;
  logic        dec_uses_rs;
  logic        dec_uses_rt;
  logic        dec_wr_en;
  logic [4:0]  dec_wr_reg;
  logic        dec_is_load;
  logic        mem_busy;

  logic [1:0]  forward_a, forward_b;
  logic        stall_fetch, stall_decode, bubble_execute, freeze;
  logic [15:0] stall_cycles;

  logic [1:0]  s_forward_a, s_forward_b;
  logic        s_stall_fetch, s_stall_decode, s_bubble_execute, s_freeze;
  logic [3:0]  s_stall_cycles;

  int checks   = 0;
  int failures = 0;

  hazard_controller #(.CNT_W(16)) u_dut (
    .clk            (clk),
    .reset          (reset),
    .dec_valid      (dec_valid),
    .rs             (rs),
    .rt             (rt),
    .dec_uses_rs    (dec_uses_rs),
    .dec_uses_rt    (dec_uses_rt),
    .dec_wr_en      (dec_wr_en),
    .dec_wr_reg     (dec_wr_reg),
    .dec_is_load    (dec_is_load),
    .mem_busy       (mem_busy),
    .forward_a      (forward_a),
    .forward_b      (forward_b),
    .stall_fetch    (stall_fetch),
    .stall_decode   (stall_decode),
    .bubble_execute (bubble_execute),
    .freeze         (freeze),
    .stall_cycles   (stall_cycles)
  );

  hazard_controller #(.CNT_W(4)) u_dut_sat (
    .clk            (clk),
    .reset          (reset),
    .dec_valid      (dec_valid),
    .rs             (rs),
    .rt             (rt),
    .dec_uses_rs    (dec_uses_rs),
    .dec_uses_rt    (dec_uses_rt),
    .dec_wr_en      (dec_wr_en),
    .dec_wr_reg     (dec_wr_reg),
    .dec_is_load    (dec_is_load),
    .mem_busy       (mem_busy),
    .forward_a      (s_forward_a),
    .forward_b      (s_forward_b),
    .stall_fetch    (s_stall_fetch),
    .stall_decode   (s_stall_decode),
    .bubble_execute (s_bubble_execute),
    .freeze         (s_freeze),
    .stall_cycles   (s_stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Advance one clock edge; inputs change shortly after the edge.
  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic ua,
                       input logic [4:0] b, input logic ub, input logic we,
                       input logic [4:0] wr, input logic ld);
    dec_valid   = v;
    rs          = a;
    dec_uses_rs = ua;
    rt          = b;
    dec_uses_rt = ub;
    dec_wr_en   = we;
    dec_wr_reg  = wr;
    dec_is_load = ld;
    #1;
  endtask

  task automatic idle();
    drive(1'b0, 5'd0, 1'b0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
  endtask

  initial begin
    mem_busy = 1'b0;
    reset    = 1'b1;
    drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b1, 5'd3, 1'b0);
    tick();
    tick();
    // Reset state
    chk("rst_fwd_a",   {30'd0, forward_a},      32'd0);
    chk("rst_fwd_b",   {30'd0, forward_b},      32'd0);
    chk("rst_stall_f", {31'd0, stall_fetch},    32'd0);
    chk("rst_stall_d", {31'd0, stall_decode},   32'd0);
    chk("rst_bubble",  {31'd0, bubble_execute}, 32'd0);
    chk("rst_freeze",  {31'd0, freeze},         32'd0);
    chk("rst_count",   {16'd0, stall_cycles},   32'd0);

    reset = 1'b0;
    drive(1'b1, 5'd3, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("post_rst_fwd_a", {30'd0, forward_a}, 32'd0);
    tick();

    // EX then MEM forward: add r5 ; sub r6 <- r5 ; reader of r5
    drive(1'b1, 5'd1, 1'b1, 5'd2, 1'b1, 1'b1, 5'd5, 1'b0);
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd0, 1'b0, 1'b1, 5'd6, 1'b0);
    chk("ex_fwd_a",   {30'd0, forward_a},    32'd2);
    chk("ex_nostall", {31'd0, stall_decode}, 32'd0);
    tick();
    drive(1'b1, 5'd5, 1'b1, 5'd5, 1'b0, 1'b1, 5'd8, 1'b0);
    chk("mem_fwd_a",      {30'd0, forward_a}, 32'd1);
    chk("unused_rt_fwd",  {30'd0, forward_b}, 32'd0);
    tick();

    // Priority: two writers of r7, then a reader of r7 that writes r0
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0);
    tick();
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd7, 1'b0);
    tick();
    drive(1'b1, 5'd7, 1'b1, 5'd7, 1'b1, 1'b1, 5'd0, 1'b0);
    chk("prio_fwd_a", {30'd0, forward_a}, 32'd2);
    chk("prio_fwd_b", {30'd0, forward_b}, 32'd2);
    tick();
    drive(1'b1, 5'd0, 1'b1, 5'd0, 1'b1, 1'b0, 5'd0, 1'b0);
    chk("r0_fwd_a", {30'd0, forward_a}, 32'd0);
    chk("r0_fwd_b", {30'd0, forward_b}, 32'd0);
    tick();

    // Load-use: lw r4 ; reader with rt=4 -> two stall cycles
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd4, 1'b1);
    chk("lw_issue_nostall", {31'd0, stall_decode}, 32'd0);
    tick();
    drive(1'b1, 5'd1, 1'b1, 5'd4, 1'b1, 1'b1, 5'd9, 1'b0);
    chk("lu1_stall_d", {31'd0, stall_decode},   32'd1);
    chk("lu1_stall_f", {31'd0, stall_fetch},    32'd1);
    chk("lu1_bubble",  {31'd0, bubble_execute}, 32'd1);
    chk("lu1_fwd_b",   {30'd0, forward_b},      32'd0);
    chk("lu1_freeze",  {31'd0, freeze},         32'd0);
    tick();
    chk("lu2_stall_d", {31'd0, stall_decode},   32'd1);
    chk("lu2_bubble",  {31'd0, bubble_execute}, 32'd1);
    chk("lu2_fwd_b",   {30'd0, forward_b},      32'd0);
    chk("lu2_count",   {16'd0, stall_cycles},   32'd1);
    tick();
    chk("lu3_stall_d", {31'd0, stall_decode},   32'd0);
    chk("lu3_bubble",  {31'd0, bubble_execute}, 32'd0);
    chk("lu3_fwd_b",   {30'd0, forward_b},      32'd0);
    chk("lu3_count",   {16'd0, stall_cycles},   32'd2);
    tick();
    idle();
    tick();

    // Freeze in the middle of a load-use stall
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd10, 1'b1);
    tick();
    drive(1'b1, 5'd10, 1'b1, 5'd0, 1'b0, 1'b1, 5'd11, 1'b0);
    chk("fz_pre_bubble", {31'd0, bubble_execute}, 32'd1);
    tick();
    mem_busy = 1'b1;
    #1;
    for (int i = 0; i < 3; i++) begin
      chk("fz_freeze",  {31'd0, freeze},         32'd1);
      chk("fz_bubble",  {31'd0, bubble_execute}, 32'd0);
      chk("fz_stall_d", {31'd0, stall_decode},   32'd1);
      chk("fz_count",   {16'd0, stall_cycles},   32'd3);
      tick();
    end
    mem_busy = 1'b0;
    #1;
    chk("fz_rel_bubble", {31'd0, bubble_execute}, 32'd1);
    chk("fz_rel_freeze", {31'd0, freeze},         32'd0);
    tick();
    chk("fz_done_stall", {31'd0, stall_decode}, 32'd0);
    chk("fz_done_count", {16'd0, stall_cycles}, 32'd4);
    tick();
    idle();
    tick();

    // Saturation: 10 load-use pairs = 20 stall cycles
    for (int i = 0; i < 10; i++) begin
      drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd12, 1'b1);
      tick();
      drive(1'b1, 5'd12, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
      tick();
      tick();
      tick();
    end
    chk("sat_count4",  {28'd0, s_stall_cycles}, 32'd15);
    chk("sat_count16", {16'd0, stall_cycles},   32'd24);

    // Reset in the middle of a stall
    drive(1'b1, 5'd0, 1'b0, 5'd0, 1'b0, 1'b1, 5'd13, 1'b1);
    tick();
    drive(1'b1, 5'd13, 1'b1, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0);
    chk("mr_pre_stall", {31'd0, stall_decode}, 32'd1);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    chk("mr_stall_d", {31'd0, stall_decode},   32'd0);
    chk("mr_bubble",  {31'd0, bubble_execute}, 32'd0);
    chk("mr_count",   {16'd0, stall_cycles},   32'd0);
    chk("mr_count4",  {28'd0, s_stall_cycles}, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
`default_nettype wire
